// File: rtl/leg_trace_pkg.sv
// Shared types and record layout for the LEG execution trace buffer.
// TRACE_FLAGS_EN adds the 4-bit NZCV field at the top of each record.
package leg_trace_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED,
    POST  = ST_POST,
    DONE  = ST_DONE
  } trace_state_t;

`ifdef TRACE_FLAGS_EN
  localparam int unsigned FLAGS_W = 4;
`else
  localparam int unsigned FLAGS_W = 0;
`endif

  // Record layout, LSB first: instr, pc, then flags when enabled.
  localparam int unsigned INSTR_LSB = 0;

  function automatic int unsigned pc_lsb(input int unsigned instr_w);
    return instr_w;
  endfunction

  function automatic int unsigned flags_lsb(input int unsigned addr_w, input int unsigned instr_w);
    return addr_w + instr_w;
  endfunction

  function automatic int unsigned rec_width(input int unsigned addr_w, input int unsigned instr_w);
    return addr_w + instr_w + FLAGS_W;
  endfunction

endpackage

// File: rtl/exec_trace_buffer_if.sv
// Snoop and read-back bus of the trace buffer; the buffer sits on the slave side.
// Record width follows TRACE_FLAGS_EN through the package.
interface exec_trace_buffer_if
  import leg_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned REC_W = rec_width(ADDR_W, INSTR_W);

  logic               fetch;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         flags;
  logic               rd_req;
  logic [PTR_W-1:0]   rd_addr;
  logic               rd_valid;
  logic [REC_W-1:0]   rd_data;

  modport master (
    output fetch, pc, instr, flags, rd_req, rd_addr,
    input  rd_valid, rd_data
  );

  modport slave (
    input  fetch, pc, instr, flags, rd_req, rd_addr,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/exec_trace_buffer_trace_ram.sv
// Simple dual-port record store: one write port, one registered read port.
// Contents are deliberately left unreset.
module trace_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned REC_W = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [REC_W-1:0] wdata,
  input  logic             re,
  input  logic [PTR_W-1:0] raddr,
  output logic [REC_W-1:0] rdata
);
  logic [REC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/exec_trace_buffer.sv
// Circular execution-trace capture with PC-match/forced trigger and post-trigger count.
// Build option TRACE_FLAGS_EN stores NZCV flags in each record.
module exec_trace_buffer
  import leg_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned REC_W  = rec_width(ADDR_W, INSTR_W)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  exec_trace_buffer_if.slave bus,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [ADDR_W-1:0] trig_pc,
  input  logic              force_trig,
  input  logic [PTR_W-1:0]  post_count,
  output logic [1:0]        state,
  output logic [PTR_W:0]    count,
  output logic [PTR_W-1:0]  trig_index,
  output logic              done
);
  localparam int unsigned PC_LSB    = pc_lsb(INSTR_W);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  trace_state_t     st_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] remaining;
  logic [PTR_W-1:0] trig_slot;
  logic [PTR_W-1:0] oldest;
  logic [PTR_W-1:0] raddr;
  logic [REC_W-1:0] wdata;
  logic [REC_W-1:0] ram_q;
  logic             wr_en;
  logic             rd_en;
  logic             trig_hit;
  logic             rd_hit;
  logic             rd_valid_q;
  logic             rd_hit_q;

  assign trig_hit = (bus.fetch && trig_en && (bus.pc == trig_pc)) || force_trig;
  assign wr_en    = !arm && bus.fetch && ((st_q == ARMED) || (st_q == POST));
  assign oldest   = (count == CNT_FULL) ? wr_ptr : '0;
  assign raddr    = oldest + bus.rd_addr;
  assign rd_hit   = {1'b0, bus.rd_addr} < count;
  assign rd_en    = bus.rd_req && (st_q == DONE);

  always_comb begin
    wdata = '0;
    wdata[INSTR_LSB +: INSTR_W] = bus.instr;
    wdata[PC_LSB +: ADDR_W]     = bus.pc;
`ifdef TRACE_FLAGS_EN
    wdata[flags_lsb(ADDR_W, INSTR_W) +: 4] = bus.flags;
`endif
  end

`ifndef TRACE_FLAGS_EN
  logic unused_flags;
  assign unused_flags = ^bus.flags;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      st_q       <= IDLE;
      wr_ptr     <= '0;
      count      <= '0;
      remaining  <= '0;
      trig_slot  <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_hit_q   <= rd_hit;
      if (arm) begin
        st_q      <= ARMED;
        wr_ptr    <= '0;
        count     <= '0;
        remaining <= '0;
        trig_slot <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (count != CNT_FULL) count <= count + (PTR_W + 1)'(1);
        end
        case (st_q)
          ARMED: begin
            if (trig_hit) begin
              remaining <= post_count;
              st_q      <= (post_count == '0) ? DONE : POST;
              // A forced trigger with nothing to follow points at the newest record
              // instead of an empty next slot.
              if (bus.fetch)              trig_slot <= wr_ptr;
              else if (post_count != '0)  trig_slot <= wr_ptr;
              else if (count == '0)       trig_slot <= '0;
              else                        trig_slot <= wr_ptr - PTR_W'(1);
            end
          end
          POST: begin
            if (bus.fetch) begin
              remaining <= remaining - PTR_W'(1);
              if (remaining == PTR_W'(1)) st_q <= DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_ram (
    .clk   (CLOCK_50),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (ram_q)
  );

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = (rd_valid_q && rd_hit_q) ? ram_q : '0;
  assign state        = st_q;
  assign done         = (st_q == DONE);
  assign trig_index   = trig_slot - oldest;
endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed bench for exec_trace_buffer at DEPTH=8; flag checks apply when TRACE_FLAGS_EN is defined.
module tb_exec_trace_buffer;
  import leg_trace_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned REC_W   = rec_width(ADDR_W, INSTR_W);
  localparam logic [31:0] IMASK   = 32'h1234_5678;

  typedef struct {
    logic [PTR_W-1:0] addr;
    logic             in_range;
    logic [31:0]      pc;
    logic [3:0]       fl;
  } rd_vec_t;

  logic              CLOCK_50;
  logic              reset;
  logic              arm;
  logic              trig_en;
  logic [ADDR_W-1:0] trig_pc;
  logic              force_trig;
  logic [PTR_W-1:0]  post_count;
  logic [1:0]        state;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  trig_index;
  logic              done;

  int checks   = 0;
  int failures = 0;
  rd_vec_t tbl[$];

  exec_trace_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  exec_trace_buffer #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .bus        (bus.slave),
    .arm        (arm),
    .trig_en    (trig_en),
    .trig_pc    (trig_pc),
    .force_trig (force_trig),
    .post_count (post_count),
    .state      (state),
    .count      (count),
    .trig_index (trig_index),
    .done       (done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [REC_W-1:0] exp_rec(input logic [31:0] p, input logic [3:0] f);
    logic [3:0] unused_f;
    unused_f = f;
`ifdef TRACE_FLAGS_EN
    return {f, p, p ^ IMASK};
`else
    return {p, p ^ IMASK};
`endif
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] p, input logic [3:0] f);
    bus.fetch = 1'b1;
    bus.pc    = p;
    bus.instr = p ^ IMASK;
    bus.flags = f;
    step();
    bus.fetch = 1'b0;
  endtask

  // Back-to-back reads: one result per cycle, checked against the table.
  task automatic run_table(input string tag);
    logic [REC_W-1:0] exp;
    bus.rd_req  = 1'b1;
    bus.rd_addr = tbl[0].addr;
    step();
    for (int i = 0; i < tbl.size(); i++) begin
      exp = tbl[i].in_range ? exp_rec(tbl[i].pc, tbl[i].fl) : '0;
      chk($sformatf("%s rd_valid[%0d]", tag, i), bus.rd_valid, 1);
      chk($sformatf("%s rd_data[%0d]", tag, i), bus.rd_data, exp);
      if (i + 1 < tbl.size()) begin
        bus.rd_addr = tbl[i + 1].addr;
        step();
      end
    end
    bus.rd_req = 1'b0;
    step();
    chk({tag, " rd_valid idle"}, bus.rd_valid, 0);
    tbl.delete();
  endtask

  initial begin
    reset      = 1'b1;
    arm        = 1'b0;
    trig_en    = 1'b0;
    trig_pc    = '0;
    force_trig = 1'b0;
    post_count = '0;
    bus.fetch  = 1'b0;
    bus.pc     = '0;
    bus.instr  = '0;
    bus.flags  = '0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    step();
    step();
    chk("reset state", state, 0);
    chk("reset count", count, 0);
    chk("reset done", done, 0);
    chk("reset trig_index", trig_index, 0);
    chk("reset rd_valid", bus.rd_valid, 0);
    chk("reset rd_data", bus.rd_data, 0);
    reset = 1'b0;
    step();
    do_fetch(32'd4, 4'd1);
    chk("idle ignores fetch", count, 0);

    // No wrap: trigger at pc 8, two post records.
    trig_en = 1'b1; trig_pc = 32'd8; post_count = 3'd2;
    do_arm();
    chk("armed state", state, 1);
    do_fetch(32'd0, 4'd0);
    do_fetch(32'd4, 4'd1);
    do_fetch(32'd8, 4'd2);
    chk("nowrap post state", state, 2);
    do_fetch(32'd12, 4'd3);
    chk("nowrap done early", done, 0);
    do_fetch(32'd16, 4'd4);
    chk("nowrap done", done, 1);
    chk("nowrap state", state, 3);
    chk("nowrap count", count, 5);
    chk("nowrap trig_index", trig_index, 2);
    for (int i = 0; i < 5; i++)
      tbl.push_back('{addr: PTR_W'(i), in_range: 1'b1, pc: 32'(4 * i), fl: 4'(i)});
    tbl.push_back('{addr: 3'd5, in_range: 1'b0, pc: 32'd0, fl: 4'd0});
    run_table("nowrap");

    // Wrap: 12 fetches, trigger at pc 36.
    trig_pc = 32'd36; post_count = 3'd2;
    do_arm();
    for (int i = 0; i < 12; i++) do_fetch(32'(4 * i), 4'(i));
    chk("wrap done", done, 1);
    chk("wrap count", count, 8);
    chk("wrap trig_index", trig_index, 5);
    do_fetch(32'd100, 4'hF);
    chk("done freezes count", count, 8);
    tbl.push_back('{addr: 3'd0, in_range: 1'b1, pc: 32'd16, fl: 4'd4});
    tbl.push_back('{addr: 3'd3, in_range: 1'b1, pc: 32'd28, fl: 4'd7});
    tbl.push_back('{addr: 3'd7, in_range: 1'b1, pc: 32'd44, fl: 4'd11});
    run_table("wrap");

    // arm together with a matching fetch: fetch discarded.
    arm = 1'b1;
    do_fetch(32'd36, 4'd9);
    arm = 1'b0;
    chk("arm+fetch state", state, 1);
    chk("arm+fetch count", count, 0);
    step();
    chk("arm+fetch still armed", state, 1);

    // Forced trigger without fetch, post_count=0, after three fetches.
    trig_en = 1'b0; post_count = 3'd0;
    do_fetch(32'd0, 4'd0);
    do_fetch(32'd4, 4'd1);
    do_fetch(32'd8, 4'b1010);
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
    chk("force0 state", state, 3);
    chk("force0 done", done, 1);
    chk("force0 count", count, 3);
    chk("force0 trig_index", trig_index, 2);
    tbl.push_back('{addr: 3'd5, in_range: 1'b0, pc: 32'd0, fl: 4'd0});
    tbl.push_back('{addr: 3'd2, in_range: 1'b1, pc: 32'd8, fl: 4'b1010});
    tbl.push_back('{addr: 3'd0, in_range: 1'b1, pc: 32'd0, fl: 4'd0});
    run_table("force0");
`ifdef TRACE_FLAGS_EN
    bus.rd_req = 1'b1; bus.rd_addr = 3'd2;
    step();
    bus.rd_req = 1'b0;
    chk("trigger flags", bus.rd_data[REC_W-1 -: 4], 4'b1010);
`endif

    // Forced trigger without fetch, post_count=1: trigger is the next slot.
    post_count = 3'd1;
    do_arm();
    do_fetch(32'd0, 4'd0);
    do_fetch(32'd4, 4'd1);
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
    chk("force1 state", state, 2);
    trig_en = 1'b1; trig_pc = 32'd8;
    do_fetch(32'd8, 4'd2);
    chk("force1 done", done, 1);
    chk("force1 count", count, 3);
    chk("force1 trig_index", trig_index, 2);

    // Reset in the middle of a read.
    bus.rd_req = 1'b1; bus.rd_addr = 3'd1;
    step();
    chk("midread rd_valid", bus.rd_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("midread reset rd_valid", bus.rd_valid, 0);
    chk("midread reset rd_data", bus.rd_data, 0);
    chk("midread reset state", state, 0);
    bus.rd_req = 1'b0;
    step();
    reset = 1'b0;

    // Reset during POST.
    trig_pc = 32'd0; post_count = 3'd3;
    do_arm();
    do_fetch(32'd0, 4'd0);
    chk("rpost state", state, 2);
    bus.rd_req = 1'b1; bus.rd_addr = 3'd0;
    step();
    chk("rpost rd outside done", bus.rd_valid, 0);
    #2 reset = 1'b1;
    #1;
    chk("rpost state", state, 0);
    chk("rpost count", count, 0);
    chk("rpost done", done, 0);
    step();
    reset = 1'b0;
    step();
    chk("rpost rd_valid", bus.rd_valid, 0);
    bus.rd_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
